detect_r: RTL and testbench

DETECT_R -- requirements
Module: detect_r

---
 rtl/detect_r.sv | 66 ++++++
 tb/tb_detect_r.sv | 134 +++++++++++++
 2 files changed

// File: rtl/detect_r.sv
// detect_r: synchronizes an asynchronous level input and emits a one-cycle
// registered pulse on the selected edge (rising, falling or both).
module detect_r #(
  parameter int unsigned SYNC_STAGES = 2,  // synchronizer depth, 1..4
  parameter int unsigned EDGE_MODE   = 0   // 0 rise, 1 fall, 2 both; others act as 0
) (
  input  logic clk,
  input  logic rstn,     // synchronous, active-high despite the name
  input  logic d_in,
  output logic detect
);

  localparam int unsigned N = SYNC_STAGES;

  logic [N-1:0] r_sync;
  logic         r_prev;
  logic         r_detect;
  logic         w_rise;
  logic         w_fall;
  logic         w_edge;

  // Synchronizer chain: stage 0 samples d_in, later stages shift it along.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= d_in;
      for (int i = 1; i < int'(N); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // History flop holding the previous synchronized level.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= r_sync[N-1];
    end
  end

  // Edge terms from the synchronized level and its history.
  always_comb begin
    w_rise = r_sync[N-1] & ~r_prev;
    w_fall = ~r_sync[N-1] & r_prev;
    w_edge = w_rise;
    case (EDGE_MODE)
      32'd1:   w_edge = w_fall;
      32'd2:   w_edge = w_rise | w_fall;
      default: w_edge = w_rise;
    endcase
  end

  // Register the selected edge term so detect has no path from d_in.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_detect <= 1'b0;
    end else begin
      r_detect <= w_edge;
    end
  end

  assign detect = r_detect;

endmodule

// File: tb/tb_detect_r.sv
// tb_detect_r: directed traces driven into four detect_r configurations with
// hand-computed expected pulse positions.
// Trace convention: cycle j drives rstn/d_in, then the value of detect just
// after clock edge j is recorded in bit j of the trace.
`timescale 1ns/1ps
module tb_detect_r;

  logic clk;
  logic rstn;
  logic d_in;
  logic det_def;
  logic det_both;
  logic det_s3;
  logic det_fall;

  logic [63:0] tr_def;
  logic [63:0] tr_both;
  logic [63:0] tr_s3;
  logic [63:0] tr_fall;

  int n_checks;
  int n_errors;

  detect_r #(.SYNC_STAGES(2), .EDGE_MODE(0)) u_def  (.clk(clk), .rstn(rstn), .d_in(d_in), .detect(det_def));
  detect_r #(.SYNC_STAGES(2), .EDGE_MODE(2)) u_both (.clk(clk), .rstn(rstn), .d_in(d_in), .detect(det_both));
  detect_r #(.SYNC_STAGES(3), .EDGE_MODE(0)) u_s3   (.clk(clk), .rstn(rstn), .d_in(d_in), .detect(det_s3));
  detect_r #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_fall (.clk(clk), .rstn(rstn), .d_in(d_in), .detect(det_fall));

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Mask with bits lo..hi set.
  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit_at(input int b);
    logic [63:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // Run n cycles; g_pat marks cycles with a brief mid-cycle inverted glitch.
  task automatic run_trace(input logic [63:0] d_pat, input logic [63:0] r_pat,
                           input logic [63:0] g_pat, input int n);
    tr_def  = '0;
    tr_both = '0;
    tr_s3   = '0;
    tr_fall = '0;
    for (int j = 0; j < n; j++) begin
      rstn = r_pat[j];
      d_in = d_pat[j];
      if (g_pat[j]) begin
        #2 d_in = ~d_pat[j];
        #2 d_in = d_pat[j];
      end
      @(posedge clk);
      #1;
      tr_def[j]  = det_def;
      tr_both[j] = det_both;
      tr_s3[j]   = det_s3;
      tr_fall[j] = det_fall;
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] e_def, input logic [63:0] e_both,
                           input logic [63:0] e_s3, input logic [63:0] e_fall);
    check({tag, "_def"},  tr_def,  e_def);
    check({tag, "_both"}, tr_both, e_both);
    check({tag, "_s3"},   tr_s3,   e_s3);
    check({tag, "_fall"}, tr_fall, e_fall);
  endtask

  initial begin
    logic [63:0] rst2;
    int pulses;
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b1;
    d_in = 1'b0;
    @(posedge clk);
    #1;
    rst2 = rng(0, 1);

    // Reset then idle with d_in low: no pulses at all, detect 0 during reset.
    run_trace('0, rst2, '0, 12);
    check_all("idle", '0, '0, '0, '0);

    // Single rise held 10 cycles then fall.
    run_trace(rng(2, 11), rst2, '0, 20);
    check_all("rise10", bit_at(4), bit_at(4) | bit_at(14), bit_at(5), bit_at(14));

    // High 20, low 20, high 20, low.
    run_trace(rng(2, 21) | rng(42, 61), rst2, '0, 64);
    check_all("hlh", bit_at(4) | bit_at(44), bit_at(4) | bit_at(24) | bit_at(44),
              bit_at(5) | bit_at(45), bit_at(24));
    pulses = $countones(tr_def);
    check("hlh_count", 64'(pulses), 64'd2);

    // Level lasting exactly one sampled cycle.
    run_trace(rng(3, 3), rst2, '0, 12);
    check_all("one", bit_at(5), bit_at(5) | bit_at(6), bit_at(6), bit_at(6));

    // Reset hits while a rise is in the synchronizer; d_in stays high.
    run_trace(rng(2, 15), rst2 | rng(3, 3), '0, 16);
    check_all("rst_mid", bit_at(6), bit_at(6), bit_at(7), '0);

    // d_in held high across reset release: rise only, never a fall.
    run_trace(rng(0, 15), rst2, '0, 16);
    check_all("hi_rst", bit_at(4), bit_at(4), bit_at(5), '0);

    // Glitches between clock edges are never sampled.
    run_trace('0, rst2, rng(3, 6), 12);
    check_all("glitch", '0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
